// File: rtl/prog_loader.sv
// Serial program loader: parses framed host bytes into 18-bit program-memory writes,
// holds the MCU in reset while loading and answers each frame with ACK or NAK.
module prog_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        prog_we_o,
  output logic [9:0]  prog_waddr_o,
  output logic [17:0] prog_wdata_o,
  output logic        cpu_rst_o,
  output logic        load_err_o
);

  // state   | meaning
  // IDLE    | waiting for 0xA5 start byte
  // CNT_HI  | expecting word count high byte
  // CNT_LO  | expecting word count low byte
  // B2      | expecting word byte 2 (bits 17:16 in [1:0])
  // B1      | expecting word byte 1
  // B0      | expecting word byte 0
  // WRITE   | one-cycle program memory write
  // CSUM    | expecting checksum byte
  // RESP    | presenting ACK/NAK until the transmitter takes it
  typedef enum logic [3:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_B2, S_B1, S_B0, S_WRITE, S_CSUM, S_RESP
  } state_t;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;
  localparam int         TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_RELOAD = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q;
  logic [7:0]    sum_q;
  logic [7:0]    cnt_hi_q;
  logic [10:0]   n_q;
  logic [10:0]   wcnt_q;
  logic [1:0]    b2_q;
  logic [7:0]    b1_q;
  logic [TW-1:0] timer_q;
  logic [9:0]    addr_q;
  logic [17:0]   wdata_q;
  logic          prog_we_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          cpu_rst_q;
  logic          load_err_q;

  logic [7:0]  sum_d;
  logic [15:0] count_d;
  logic [10:0] wcnt_d;

  always_comb begin
    sum_d   = sum_q + rx_data_i;
    count_d = {cnt_hi_q, rx_data_i};
    wcnt_d  = wcnt_q + 11'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      sum_q      <= '0;
      cnt_hi_q   <= '0;
      n_q        <= '0;
      wcnt_q     <= '0;
      b2_q       <= '0;
      b1_q       <= '0;
      timer_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      prog_we_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cpu_rst_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      prog_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (rx_valid_i && rx_data_i == SYNC) begin
            state_q    <= S_CNT_HI;
            sum_q      <= '0;
            load_err_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
            timer_q    <= T_RELOAD;
          end
        end
        S_CNT_HI, S_CNT_LO, S_B2, S_B1, S_B0, S_CSUM: begin
          if (rx_valid_i) begin
            timer_q <= T_RELOAD;
            sum_q   <= sum_d;
            unique case (state_q)
              S_CNT_HI: begin
                cnt_hi_q <= rx_data_i;
                state_q  <= S_CNT_LO;
              end
              S_CNT_LO: begin
                if (count_d > 16'd1024) begin
                  state_q    <= S_RESP;
                  tx_data_q  <= NAK;
                  tx_valid_q <= 1'b1;
                  load_err_q <= 1'b1;
                end else if (count_d == 16'd0) begin
                  state_q <= S_CSUM;
                end else begin
                  state_q <= S_B2;
                  n_q     <= count_d[10:0];
                  wcnt_q  <= '0;
                  addr_q  <= '0;
                end
              end
              S_B2: begin
                b2_q    <= rx_data_i[1:0];
                state_q <= S_B1;
              end
              S_B1: begin
                b1_q    <= rx_data_i;
                state_q <= S_B0;
              end
              S_B0: begin
                wdata_q   <= {b2_q, b1_q, rx_data_i};
                prog_we_q <= 1'b1;
                state_q   <= S_WRITE;
              end
              default: begin
                // checksum byte itself is compared against the sum so far
                state_q    <= S_RESP;
                tx_valid_q <= 1'b1;
                if (rx_data_i == sum_q) begin
                  tx_data_q <= ACK;
                end else begin
                  tx_data_q  <= NAK;
                  load_err_q <= 1'b1;
                end
              end
            endcase
          end else if (timer_q == '0) begin
            state_q    <= S_RESP;
            tx_data_q  <= NAK;
            tx_valid_q <= 1'b1;
            load_err_q <= 1'b1;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_WRITE: begin
          addr_q  <= addr_q + 10'd1;
          wcnt_q  <= wcnt_d;
          state_q <= (wcnt_d == n_q) ? S_CSUM : S_B2;
        end
        S_RESP: begin
          if (tx_ready_i) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_IDLE;
            if (tx_data_q == ACK) cpu_rst_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign prog_we_o    = prog_we_q;
  assign prog_waddr_o = addr_q;
  assign prog_wdata_o = wdata_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign load_err_o   = load_err_q;

endmodule
